// File: rtl/ula_pkg.sv
// Shared types for the sequential ALU (ula_seq).
// Build option ULA_MUL_EN adds the iterative multiply op and MUL state.
package ula_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_ADC  = 5'b00001,
        OP_INC  = 5'b00011,
        OP_SBB  = 5'b00100,
        OP_SUB  = 5'b00101,
        OP_DEC  = 5'b00110,
        OP_SHL1 = 5'b01000,
        OP_SAR1 = 5'b01001,
        OP_SHLB = 5'b01010,
        OP_SARB = 5'b01011,
        OP_SHRB = 5'b01100,
`ifdef ULA_MUL_EN
        OP_MUL  = 5'b01101,
`endif
        OP_ZERO = 5'b10000,
        OP_AND  = 5'b10001,
        OP_NAB  = 5'b10010,
        OP_B    = 5'b10011,
        OP_ANB  = 5'b10100,
        OP_A    = 5'b10101,
        OP_XOR  = 5'b10110,
        OP_OR   = 5'b10111,
        OP_NOR  = 5'b11000,
        OP_XNOR = 5'b11001,
        OP_NA   = 5'b11010,
        OP_NAOB = 5'b11011,
        OP_NB   = 5'b11100,
        OP_AONB = 5'b11101,
        OP_NAND = 5'b11110,
        OP_ONE  = 5'b11111
    } ula_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef ULA_MUL_EN
        , MUL
`endif
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic o;
    } flags_t;

endpackage

// File: rtl/ula_seq_comb.sv
// Single-cycle ALU datapath: every op that completes in one cycle.
// Shift-by-B ops appear here only for the zero-amount case.
module ula_seq_comb
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  ula_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cst,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] sum;
    logic             cin;
    logic             cout;
    logic             ovf;

    // Subtraction is A + ~B + cin, so C reads as "no borrow".
    always_comb begin
        x   = b;
        cin = 1'b0;
        case (op)
            OP_ADC: cin = cst;
            OP_INC: x = WIDTH'(1);
            OP_SBB: begin x = ~b; cin = cst; end
            OP_SUB: begin x = ~b; cin = 1'b1; end
            OP_DEC: begin x = ~WIDTH'(1); cin = 1'b1; end
            default: ;
        endcase
    end

    assign {cout, sum} = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, cin};
    assign ovf = (a[WIDTH-1] == x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        logic c;
        logic o;
        result = '0;
        c      = 1'b0;
        o      = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_INC,
            OP_SBB, OP_SUB, OP_DEC: begin
                result = sum;
                c      = cout;
                o      = ovf;
            end
            OP_SHL1: begin
                result = {a[WIDTH-2:0], 1'b0};
                c      = a[WIDTH-1];
            end
            OP_SAR1: begin
                result = {a[WIDTH-1], a[WIDTH-1:1]};
                c      = a[0];
            end
            OP_SHLB, OP_SARB, OP_SHRB: result = a;
            OP_ZERO: result = '0;
            OP_AND:  result = a & b;
            OP_NAB:  result = ~a & b;
            OP_B:    result = b;
            OP_ANB:  result = a & ~b;
            OP_A:    result = a;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_NOR:  result = ~a & ~b;
            OP_XNOR: result = ~(a ^ b);
            OP_NA:   result = ~a;
            OP_NAOB: result = ~a | b;
            OP_NB:   result = ~b;
            OP_AONB: result = a | ~b;
            OP_NAND: result = ~a | ~b;
            OP_ONE:  result = WIDTH'(1);
            default: result = '0;
        endcase
        flags = '{(result == '0), c, result[WIDTH-1], o};
    end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready handshakes, stored carry and
// iterative shift-by-B; ULA_MUL_EN adds an iterative multiply.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_o
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work;
    ula_op_t          sop;
    logic             cst;
    flags_t           fl;

    ula_op_t          opc;
    logic [WIDTH-1:0] c_res;
    flags_t           c_fl;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_c;
    logic             ofree;
    logic             fire;
    logic             by_b;
    logic             last;

    assign opc = ula_op_t'(op);

    ula_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (opc),
        .a      (a),
        .b      (b),
        .cst    (cst),
        .result (c_res),
        .flags  (c_fl)
    );

    assign ofree    = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && ofree;
    assign fire     = in_valid && in_ready;
    assign by_b     = opc inside {OP_SHLB, OP_SARB, OP_SHRB};
    assign last     = (cnt == CNT_W'(1));

    assign {flag_z, flag_c, flag_n, flag_o} = fl;

    always_comb begin
        sh_nxt = work >> 1;
        sh_c   = work[0];
        unique case (1'b1)
            sop == OP_SHLB: {sh_c, sh_nxt} = {work, 1'b0};
            sop == OP_SARB: sh_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
            default: ;
        endcase
    end

`ifdef ULA_MUL_EN
    // Shift-add: high half accumulates, multiplier drains from the low half.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     psum;

    assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, work} : '0);
    assign mul_nxt = {psum, prod[WIDTH-1:1]};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            sop       <= OP_ADD;
            cst       <= 1'b0;
            fl        <= '0;
            result    <= '0;
            out_valid <= 1'b0;
`ifdef ULA_MUL_EN
            prod      <= '0;
`endif
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (by_b && b[SHAMT_W-1:0] != '0) begin
                            work  <= a;
                            sop   <= opc;
                            cnt   <= {1'b0, b[SHAMT_W-1:0]};
                            state <= SHIFT;
`ifdef ULA_MUL_EN
                        end else if (opc == OP_MUL) begin
                            work  <= a;
                            prod  <= {{WIDTH{1'b0}}, b};
                            cnt   <= CNT_W'(WIDTH);
                            state <= MUL;
`endif
                        end else begin
                            result    <= c_res;
                            fl        <= c_fl;
                            cst       <= c_fl.c;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Final step waits for a free output; count stays at 1.
                    if (!last) begin
                        work <= sh_nxt;
                        cnt  <= cnt - CNT_W'(1);
                    end else if (ofree) begin
                        work      <= sh_nxt;
                        cnt       <= '0;
                        result    <= sh_nxt;
                        fl        <= '{(sh_nxt == '0), sh_c,
                                       sh_nxt[WIDTH-1], 1'b0};
                        cst       <= sh_c;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef ULA_MUL_EN
                MUL: begin
                    if (!last) begin
                        prod <= mul_nxt;
                        cnt  <= cnt - CNT_W'(1);
                    end else if (ofree) begin
                        prod      <= mul_nxt;
                        cnt       <= '0;
                        result    <= mul_nxt[WIDTH-1:0];
                        fl        <= '{(mul_nxt[WIDTH-1:0] == '0),
                                       |mul_nxt[2*WIDTH-1:WIDTH],
                                       mul_nxt[WIDTH-1], 1'b0};
                        cst       <= |mul_nxt[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq (default build, WIDTH=16).
module tb_ula_seq;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  fl;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        flag_z, flag_c, flag_n, flag_o;

    int   nchk = 0;
    int   npass = 0;
    exp_t q[$];
    logic mcst = 1'b0;

    ula_seq #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_o    (flag_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            npass++;
    endtask

    function automatic exp_t model(input logic [4:0] o,
                                   input logic [15:0] x, y,
                                   input logic ci);
        exp_t e;
        logic [15:0] r;
        logic signed [15:0] t;
        logic c, v;
        int n, s, sx, sy, u;
        r = '0; c = 1'b0; v = 1'b0;
        n = int'(y[3:0]);
        sx = $signed(x); sy = $signed(y);
        s = 0; u = 0;
        case (o)
            5'b00000, 5'b00001: begin
                s = sx + sy + int'(o[0] & ci);
                u = int'(x) + int'(y) + int'(o[0] & ci);
                r = u[15:0]; c = u > 65535;
                v = s > 32767 || s < -32768;
            end
            5'b00011: begin
                r = x + 16'd1; c = (x == 16'hFFFF); v = (x == 16'h7FFF);
            end
            5'b00100, 5'b00101: begin
                s = sx - sy - ((o[0] | ci) ? 0 : 1);
                u = int'(x) - int'(y) - ((o[0] | ci) ? 0 : 1);
                r = u[15:0]; c = u >= 0;
                v = s > 32767 || s < -32768;
            end
            5'b00110: begin
                r = x - 16'd1; c = (x != 0); v = (x == 16'h8000);
            end
            5'b01000: begin r = x << 1; c = x[15]; end
            5'b01001: begin t = $signed(x) >>> 1; r = t; c = x[0]; end
            5'b01010: begin r = x << n; c = (n != 0) ? x[16-n] : 1'b0; end
            5'b01011: begin
                t = $signed(x) >>> n; r = t;
                c = (n != 0) ? x[n-1] : 1'b0;
            end
            5'b01100: begin r = x >> n; c = (n != 0) ? x[n-1] : 1'b0; end
            5'b10001: r = x & y;
            5'b10010: r = ~x & y;
            5'b10011: r = y;
            5'b10100: r = x & ~y;
            5'b10101: r = x;
            5'b10110: r = x ^ y;
            5'b10111: r = x | y;
            5'b11000: r = ~(x | y);
            5'b11001: r = ~(x ^ y);
            5'b11010: r = ~x;
            5'b11011: r = ~x | y;
            5'b11100: r = ~y;
            5'b11101: r = x | ~y;
            5'b11110: r = ~(x & y);
            5'b11111: r = 16'd1;
            default:  r = '0;
        endcase
        e.res = r;
        e.fl  = {r == 16'd0, c, r[15], v};
        return e;
    endfunction

    task automatic issue(input logic [4:0] o, input logic [15:0] x, y,
                         output int waited);
        exp_t e;
        bit ok;
        op = o; a = x; b = y; in_valid = 1'b1;
        waited = 0; ok = 1'b0;
        while (!ok && waited <= 200) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        else begin
            e = model(o, x, y, mcst);
            mcst = e.fl[2];
            q.push_back(e);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", {16'd0, result}, {16'd0, e.res});
                chk("flags", {28'd0, flag_z, flag_c, flag_n, flag_o},
                    {28'd0, e.fl});
            end
        end
    end

    initial begin
        int w;
        logic [15:0] r0;
        logic [3:0]  f0;
        int late;

        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flag_z, flag_c, flag_n, flag_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;

        issue(5'b00000, 16'h7FFF, 16'h0001, w);
        chk("add_lat1", {31'd0, out_valid}, 32'd1);
        chk("add_res", {16'd0, result}, 32'h8000);
        chk("add_flags", {28'd0, flag_z, flag_c, flag_n, flag_o}, 32'b0011);
        issue(5'b00101, 16'h0005, 16'h0005, w);
        issue(5'b00000, 16'hFFFF, 16'h0001, w);
        issue(5'b00001, 16'h0001, 16'h0001, w);
        chk("adc_res", {16'd0, result}, 32'h0003);

        // SAR by 3: three-edge latency, input closed meanwhile
        drain();
        issue(5'b01011, 16'h8005, 16'd3, w);
        chk("sar_busy_rdy", {31'd0, in_ready}, 32'd0);
        chk("sar_busy_vld", {31'd0, out_valid}, 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            chk("sar_mid_rdy", {31'd0, in_ready}, 32'd0);
            chk("sar_mid_vld", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clock); #1;
        chk("sar_done_vld", {31'd0, out_valid}, 32'd1);
        chk("sar_res", {16'd0, result}, 32'hF000);
        chk("sar_c", {31'd0, flag_c}, 32'd1);

        // Backpressure
        drain();
        out_ready = 1'b0;
        issue(5'b10110, 16'hA5A5, 16'h0FF0, w);
        r0 = result;
        f0 = {flag_z, flag_c, flag_n, flag_o};
        op = 5'b00000; a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("bp_res", {16'd0, result}, {16'd0, r0});
            chk("bp_flags", {28'd0, flag_z, flag_c, flag_n, flag_o},
                {28'd0, f0});
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
            chk("bp_vld", {31'd0, out_valid}, 32'd1);
        end
        chk("bp_q", q.size(), 1);
        @(posedge clock);
        #1 out_ready = 1'b1;
        issue(5'b00000, 16'h1234, 16'h1111, w);
        chk("bp_release", w, 0);
        for (int i = 0; i < 4; i++) begin
            issue(5'b00000, 16'(i * 16'h4001), 16'h8000, w);
            chk("b2b", w, 0);
        end

        // Random ops across the whole code space
        for (int i = 0; i < 60; i++) begin
            issue(5'($urandom_range(0, 31)), 16'($urandom),
                  16'($urandom), w);
        end
        drain();

        // Reset in the middle of a shift
        issue(5'b01010, 16'h0001, 16'd10, w);
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_res", {16'd0, result}, 32'd0);
        chk("mid_rst_flags", {28'd0, flag_z, flag_c, flag_n, flag_o}, 32'd0);
        q.delete();
        mcst = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        late = 0;
        repeat (15) begin
            @(negedge clock);
            if (out_valid) late++;
        end
        chk("no_late", late, 0);

        // Carry restarts from 0 after reset
        issue(5'b00001, 16'h0001, 16'h0001, w);
        drain();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Sequential, parametrised successor to the team's 16-bit combinational ALU. Keeps the same 5-bit operation codes and Z/C/N/O flags.
- Adds valid/ready handshakes on input and output, and a registered result.
- Adds a stored-carry register for add-with-carry and subtract-with-borrow.
- Adds iterative multi-bit shifts under an FSM.
- Sits between the register-file read stage and write-back in the datapath.

Parameters:
- WIDTH, 16: operand/result width; must be a power of two, ≥8.
- SHAMT_W, $clog2(WIDTH): localparam; shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at a clock edge.
- op  in  5  operation code.
- a  in  WIDTH  operand A (signed).
- b  in  WIDTH  operand B (signed); shift amount for shift-by-B ops.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- flag_z, flag_c, flag_n, flag_o  out  1 each  registered flags for the result.

Behaviour:
- Reset (async, reset_n=0): state IDLE, out_valid=0, result=0, all flags=0, stored carry=0, shift counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Operation codes (binary; "~" is bitwise NOT):
  - 00000 A+B
  - 00001 A+B+Cst (Cst = stored carry)
  - 00011 A+1
  - 00100 A-B-~Cst (borrow = ~Cst)
  - 00101 A-B
  - 00110 A-1
  - 01000 SHL by 1
  - 01001 SAR by 1
  - 01010 SHL by B
  - 01011 SAR by B
  - 01100 SHR (logical) by B
  - 10000 0
  - 10001 A&B
  - 10010 ~A&B
  - 10011 B
  - 10100 A&~B
  - 10101 A
  - 10110 A^B
  - 10111 A|B
  - 11000 ~A&~B
  - 11001 ~(A^B)
  - 11010 ~A
  - 11011 ~A|B
  - 11100 ~B
  - 11101 A|~B
  - 11110 ~A|~B
  - 11111 result = 1
  - Any other code: result 0.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - Add: C = carry out of bit WIDTH-1; O = signed overflow.
  - Subtract: computed as A+~B+cin; C = carry out (1 = no borrow); O = signed overflow.
  - Shifts: C = last bit shifted out; O=0.
  - Logic/constant/undefined ops: C=0, O=0.
- Single-cycle ops (all non-shift-by-B ops, and shift-by-B with amount 0):
  - Result and flags are registered at the accepting edge; out_valid=1 the next cycle.
  - Latency 1; throughput 1/cycle under continuous out_ready.
  - Shift-by-B with amount 0: result=A, C=0.
- Shift-by-B with amount n≥1:
  - Accept edge loads the work register with A and the counter with n; state becomes SHIFT.
  - Each edge in SHIFT shifts one bit and decrements the counter.
  - On the edge where the counter goes 1→0, result and flags are written, out_valid=1, and state returns to IDLE. Latency n.
- Final-step stall: if the final step arrives while out_valid=1 && !out_ready, SHIFT holds with counter=1 until the output frees. The shift amount is never corrupted.
- Output hold: result and flags stay stable while out_valid && !out_ready. out_valid clears on an edge with out_ready=1 unless a new result is written on the same edge.
- Stored carry Cst updates to flag_c on every result write, not on consumption.
- Reset mid-SHIFT: the operation is discarded and all state returns to reset values.

Optional Feature:
- Macro ULA_MUL_EN.
- Defined: op 01101 is an unsigned multiply, computed iteratively by shift-add over WIDTH cycles in state MUL (in_ready=0).
  - result = low WIDTH bits.
  - C = 1 if the high half is nonzero.
  - O = 0.
  - Latency WIDTH; the final step stalls on a blocked output exactly as SHIFT does.
- Undefined: 01101 behaves as an undefined code (result 0, Z=1, others 0), and the MUL state and logic are absent.

Decomposition:
- Package ula_pkg: op-code enum (ula_op_t), FSM enum (IDLE, SHIFT, MUL), flags struct (z,c,n,o).
- One sub-module, ula_seq_comb: combinational single-cycle datapath (op, a, b, Cst → result, flags) for all non-iterative ops, parametrised by WIDTH.

Test Plan:
- ADD a=0x7FFF, b=0x0001 → result 0x8000, N=1, O=1, C=0, Z=0; out_valid exactly one cycle after accept.
- SUB a=0x0005, b=0x0005 → 0x0000, Z=1, C=1, O=0, N=0.
- ADD 0xFFFF+0x0001 → 0x0000, C=1, Z=1; then op 00001 a=0x0001, b=0x0001 → 0x0003, C=0.
- SAR-by-B a=0x8005, b=3 → 0xF000, C=1, N=1; in_ready=0 for the SHIFT cycles; out_valid three edges after accept.
- Backpressure: out_ready=0 for 5 cycles with a result pending → result/flags stable, in_ready=0, next op not accepted; release → next op accepted that cycle, then back-to-back ADDs at 1/cycle.
- SHL-by-B a=0x0001, b=10; drop reset_n 4 cycles after accept → out_valid=0, result=0, flags=0, state IDLE, in_ready=1 after release; no late result emitted.
